// File: rtl/word_to_byte_serializer_pkg.sv
// Shared constants and state encoding for the 16-bit to 8-bit store-path serializer.
package word_to_byte_serializer_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = WORD_W / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_e;

endpackage

// File: rtl/word_to_byte_serializer_if.sv
// Word-in / byte-out handshake bundle; slave is the serializer's view, master the producer/consumer side.
interface word_to_byte_serializer_if;
    import word_to_byte_serializer_pkg::*;

    logic [WORD_W-1:0] in_word;
    logic              in_trunc;
    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] out_byte;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_word, in_trunc, in_valid, out_ready,
        output in_ready, out_byte, out_last, out_valid
    );

    modport master (
        output in_word, in_trunc, in_valid, out_ready,
        input  in_ready, out_byte, out_last, out_valid
    );

endinterface

// File: rtl/word_to_byte_serializer_byte_select_mux.sv
// Picks the byte presented in the current state from the held word; purely combinational.
module word_to_byte_serializer_byte_select_mux
    import word_to_byte_serializer_pkg::*;
#(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic [WORD_W-1:0] word_i,
    input  state_e            state_i,
    input  logic              trunc_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              last_o
);

    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;

    assign hi = word_i[WORD_W-1:BYTE_W];
    assign lo = word_i[BYTE_W-1:0];

    always_comb begin
        byte_o = '0;
        last_o = 1'b0;
        case (state_i)
            FIRST: begin
                // A truncated word always emits its low byte, regardless of order.
                byte_o = (HI_FIRST && !trunc_i) ? hi : lo;
                last_o = trunc_i;
            end
            SECOND: begin
                byte_o = HI_FIRST ? lo : hi;
                last_o = 1'b1;
            end
            default: begin
                byte_o = '0;
                last_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/word_to_byte_serializer.sv
// Narrows 16-bit store words onto an 8-bit byte port, two bytes in either order or one truncated byte.
module word_to_byte_serializer
    import word_to_byte_serializer_pkg::*;
#(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    word_to_byte_serializer_if.slave        bus,
    input  logic                            err_clr_i,
    output logic                            trunc_err_o
);

    state_e            state_q;
    logic [WORD_W-1:0] word_q;
    logic              trunc_q;
    logic              trunc_err_q;

    logic              accept;
    logic              last_taken;

    assign bus.out_valid = (state_q != IDLE);
    assign last_taken    = bus.out_valid && bus.out_ready && bus.out_last;
    // Taking the last byte frees the holding register in the same cycle, so words stream bubble-free.
    assign bus.in_ready  = (state_q == IDLE) || last_taken;
    assign accept        = bus.in_valid && bus.in_ready;
    assign trunc_err_o   = trunc_err_q;

    word_to_byte_serializer_byte_select_mux #(
        .HI_FIRST(HI_FIRST)
    ) u_mux (
        .word_i  (word_q),
        .state_i (state_q),
        .trunc_i (trunc_q),
        .byte_o  (bus.out_byte),
        .last_o  (bus.out_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            trunc_q     <= 1'b0;
            trunc_err_q <= 1'b0;
        end else begin
            if (accept) begin
                word_q  <= bus.in_word;
                trunc_q <= bus.in_trunc;
            end

            case (state_q)
                IDLE: begin
                    if (accept) state_q <= FIRST;
                end
                FIRST: begin
                    if (bus.out_ready) begin
                        if (!trunc_q)    state_q <= SECOND;
                        else if (accept) state_q <= FIRST;
                        else             state_q <= IDLE;
                    end
                end
                SECOND: begin
                    if (bus.out_ready) state_q <= accept ? FIRST : IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Set has priority over a simultaneous clear.
            if (accept && bus.in_trunc && (bus.in_word[WORD_W-1:BYTE_W] != '0))
                trunc_err_q <= 1'b1;
            else if (err_clr_i)
                trunc_err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Directed bench with a byte scoreboard; two DUTs (HI_FIRST=0/1) share stimulus, sel picks the one observed.
module tb_word_to_byte_serializer;
    import word_to_byte_serializer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] tb_in_word = '0;
    logic        tb_in_trunc = 1'b0;
    logic        tb_in_valid = 1'b0;
    logic        tb_out_ready = 1'b0;
    logic        tb_err_clr = 1'b0;
    logic        sel = 1'b1;
    logic        terr0, terr1;

    int tests = 0;
    int fails = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    word_to_byte_serializer_if bus0 ();
    word_to_byte_serializer_if bus1 ();

    assign bus0.in_word   = tb_in_word;
    assign bus0.in_trunc  = tb_in_trunc;
    assign bus0.in_valid  = tb_in_valid;
    assign bus0.out_ready = tb_out_ready;
    assign bus1.in_word   = tb_in_word;
    assign bus1.in_trunc  = tb_in_trunc;
    assign bus1.in_valid  = tb_in_valid;
    assign bus1.out_ready = tb_out_ready;

    word_to_byte_serializer #(.HI_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .err_clr_i(tb_err_clr), .trunc_err_o(terr0)
    );
    word_to_byte_serializer #(.HI_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .err_clr_i(tb_err_clr), .trunc_err_o(terr1)
    );

    logic [7:0] o_byte;
    logic       o_last, o_valid, o_in_ready, o_terr;
    assign o_byte     = sel ? bus1.out_byte  : bus0.out_byte;
    assign o_last     = sel ? bus1.out_last  : bus0.out_last;
    assign o_valid    = sel ? bus1.out_valid : bus0.out_valid;
    assign o_in_ready = sel ? bus1.in_ready  : bus0.in_ready;
    assign o_terr     = sel ? terr1 : terr0;

    // Scoreboard: outputs taken at the coming edge are popped, words accepted at that edge are pushed.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (o_valid && tb_out_ready) begin
                exp = 'x;
                if (sb.size() > 0) exp = sb.pop_front();
                tests++;
                assert ({o_last, o_byte} === exp) else begin
                    fails++;
                    $error("FAIL byte: got last=%0b byte=%02h expected %03h", o_last, o_byte, exp);
                end
            end
            if (tb_in_valid && o_in_ready) begin
                if (tb_in_trunc) begin
                    sb.push_back({1'b1, tb_in_word[7:0]});
                end else if (sel) begin
                    sb.push_back({1'b0, tb_in_word[15:8]});
                    sb.push_back({1'b1, tb_in_word[7:0]});
                end else begin
                    sb.push_back({1'b0, tb_in_word[7:0]});
                    sb.push_back({1'b1, tb_in_word[15:8]});
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic t);
        bit done = 0;
        tb_in_word  = w;
        tb_in_trunc = t;
        tb_in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = o_in_ready;
            step();
        end
        tb_in_valid = 1'b0;
        if (!done) chk("send_timeout", 16'd0, 16'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !o_valid;
            if (!done) step();
        end
        chk("drain", {15'd0, done}, 16'd1);
    endtask

    initial begin
        // Reset held for 3 edges
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", {15'd0, o_valid}, 16'd0);
        chk("rst_last", {15'd0, o_last}, 16'd0);
        chk("rst_byte", {8'd0, o_byte}, 16'd0);
        chk("rst_terr", {15'd0, o_terr}, 16'd0);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rst_in_ready", {15'd0, o_in_ready}, 16'd1);

        // Basic two-byte, high first
        sel = 1'b1;
        tb_out_ready = 1'b1;
        send(16'hA1B2, 1'b0);
        @(negedge clk);
        chk("basic_first_byte", {8'd0, o_byte}, 16'h00A1);
        chk("basic_first_rdy", {15'd0, o_in_ready}, 16'd0);
        step();
        @(negedge clk);
        chk("basic_second_byte", {8'd0, o_byte}, 16'h00B2);
        chk("basic_second_rdy", {15'd0, o_in_ready}, 16'd1);
        drain();

        // Low byte first on the HI_FIRST=0 instance
        sel = 1'b0;
        send(16'h1234, 1'b0);
        @(negedge clk);
        chk("order_first_byte", {8'd0, o_byte}, 16'h0034);
        drain();

        // Truncation and sticky error
        sel = 1'b1;
        send(16'h00FF, 1'b1);
        drain();
        chk("terr_after_00ff", {15'd0, o_terr}, 16'd0);
        send(16'h01FF, 1'b1);
        drain();
        chk("terr_after_01ff", {15'd0, o_terr}, 16'd1);
        tb_err_clr = 1'b1;
        step();
        tb_err_clr = 1'b0;
        @(negedge clk);
        chk("terr_cleared", {15'd0, o_terr}, 16'd0);
        tb_err_clr = 1'b1;
        send(16'h8000, 1'b1);
        tb_err_clr = 1'b0;
        @(negedge clk);
        chk("terr_set_wins", {15'd0, o_terr}, 16'd1);
        drain();
        tb_err_clr = 1'b1;
        step();
        tb_err_clr = 1'b0;

        // Backpressure in FIRST then SECOND
        tb_out_ready = 1'b0;
        send(16'hCAFE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_first_byte", {8'd0, o_byte}, 16'h00CA);
            chk("bp_first_last", {15'd0, o_last}, 16'd0);
            chk("bp_first_rdy", {15'd0, o_in_ready}, 16'd0);
            step();
        end
        tb_out_ready = 1'b1;
        step();
        tb_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_second_byte", {8'd0, o_byte}, 16'h00FE);
            chk("bp_second_last", {15'd0, o_last}, 16'd1);
            chk("bp_second_rdy", {15'd0, o_in_ready}, 16'd0);
            step();
        end
        tb_out_ready = 1'b1;
        drain();

        // Streaming truncated words, one per cycle
        tb_in_valid = 1'b1;
        tb_in_trunc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tb_in_word = 16'(i);
            @(negedge clk);
            chk("stream_in_ready", {15'd0, o_in_ready}, 16'd1);
            if (i > 0) begin
                chk("stream_valid", {15'd0, o_valid}, 16'd1);
                chk("stream_byte", {8'd0, o_byte}, 16'(i - 1));
            end
            step();
        end
        tb_in_valid = 1'b0;
        @(negedge clk);
        chk("stream_tail", {8'd0, o_byte}, 16'h0007);
        drain();

        // Reset in the middle of a word
        tb_in_trunc = 1'b0;
        send(16'hBEEF, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_valid", {15'd0, o_valid}, 16'd0);
            step();
        end
        send(16'h1111, 1'b0);
        drain();

        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
